// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the register-file writeback port arbiter.
// Source indices name the requesters that feed wb_src.
package wb_port_arbiter_pkg;

  localparam int WB_SRC_PIPE = 0;
  localparam int WB_SRC_DIV  = 1;
  localparam int WB_SRC_FDIV = 2;

  localparam logic [5:0] ADDR_X0 = 6'd0;

  // After secondary k wins, the next search starts at k+1, wrapping back to the first secondary.
  function automatic int rr_next(input int k, input int n);
    return (k == n - 1) ? WB_SRC_DIV : k + 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Round-robin pick among requesters 1..N-1 starting at ptr; bit 0 is never granted.
// Purely combinational, zero latency, no backpressure of its own.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [$clog2(N)-1:0] ptr,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  assign found = |req[N-1:1];

  always_comb begin
    int c;
    c     = 0;
    grant = '0;
    idx   = '0;
    // Walk offsets from farthest to nearest so the nearest valid candidate overwrites the rest.
    for (int o = N - 2; o >= 0; o--) begin
      c = ((int'(ptr) - 1 + o) % (N - 1)) + 1;
      if (c >= 1 && req[c]) begin
        grant    = '0;
        grant[c] = 1'b1;
        idx      = $clog2(N)'(c);
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port: pipeline first, secondaries round-robin, starvation-bounded.
// Grant in cycle t appears on wb_* in t+1; one write per cycle, no output backpressure.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush_in,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic                      wb_wena,
  output logic [ADDR_W-1:0]         wb_addr,
  output logic [DATA_W-1:0]         wb_data,
  output logic [$clog2(N_REQ)-1:0]  wb_src,
  output logic                      fpu_dirty
);

  localparam int SRC_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(ADDR_X0);

  logic [SRC_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  starve_cnt;
  logic [N_REQ-1:0]  rr_grant;
  logic [SRC_W-1:0]  rr_idx;
  logic              sec_any;
  logic              force_sec;
  logic [N_REQ-1:0]  grant;
  logic [SRC_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              sec_win;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              gnt_write;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .ptr   (rr_ptr),
    .req   (req_valid),
    .grant (rr_grant),
    .idx   (rr_idx),
    .found (sec_any)
  );

  assign force_sec = (starve_cnt == CNT_W'(MAX_WAIT)) && sec_any;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (reset_n) begin
      if (force_sec) begin
        grant   = rr_grant;
        gnt_idx = rr_idx;
        gnt_any = 1'b1;
      end else if (req_valid[0] && !flush_in) begin
        grant[0] = 1'b1;
        gnt_idx  = SRC_W'(WB_SRC_PIPE);
        gnt_any  = 1'b1;
      end else if (sec_any) begin
        grant   = rr_grant;
        gnt_idx = rr_idx;
        gnt_any = 1'b1;
      end
    end
  end

  assign req_ready = grant;
  assign gnt_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign gnt_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sec_win   = gnt_any && (gnt_idx != SRC_W'(WB_SRC_PIPE));
  // x0 writes complete the handshake but never reach the regfile.
  assign gnt_write = gnt_any && (gnt_addr != X0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_wena    <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      wb_src     <= '0;
      fpu_dirty  <= 1'b0;
      rr_ptr     <= SRC_W'(WB_SRC_DIV);
      starve_cnt <= '0;
    end else begin
      wb_wena   <= gnt_write;
      fpu_dirty <= gnt_write && gnt_addr[ADDR_W-1];
      if (gnt_any) begin
        wb_addr <= gnt_addr;
        wb_data <= gnt_data;
        wb_src  <= gnt_idx;
      end
      if (sec_win) begin
        rr_ptr <= SRC_W'(rr_next(int'(gnt_idx), N_REQ));
      end
      if (sec_win || !sec_any) begin
        starve_cnt <= '0;
      end else if (grant[0] && starve_cnt != CNT_W'(MAX_WAIT)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: directed table, hand sequences for starvation/RR/reset, then random
// traffic against a queue-free behavioural model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int N = 3;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_in;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [17:0] req_addr;
  logic [95:0] req_data;
  logic        wb_wena;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic [1:0]  wb_src;
  logic        fpu_dirty;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_rr;
  int          m_starve;
  logic        m_wena;
  logic        m_fpu;
  logic [5:0]  m_addr;
  logic [31:0] m_data;
  int          m_src;

  wb_port_arbiter #(.N_REQ(N), .ADDR_W(6), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush_in  (flush_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wb_wena   (wb_wena),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_src    (wb_src),
    .fpu_dirty (fpu_dirty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scan secondaries starting at ptr, wrapping from N-1 back to 1.
  function automatic int rr_pick(input logic [2:0] v, input int ptr);
    int i;
    for (int k = 0; k < N - 1; k++) begin
      i = ptr + k;
      if (i > N - 1) i = i - (N - 1);
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int pick(input logic rst, input logic fl, input logic [2:0] v);
    int w;
    if (!rst) return -1;
    w = rr_pick(v, m_rr);
    if (m_starve == MAXW && w >= 0) return w;
    if (v[0] && !fl) return 0;
    return w;
  endfunction

  // One clock: drive, check grant before the edge, advance model, check outputs after the edge.
  task automatic cycle(input logic rst, input logic fl, input logic [2:0] v,
                       input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                       input logic [31:0] d, output logic [2:0] rdy);
    int g;
    logic [5:0]  ga [3];
    logic [31:0] gd [3];
    logic [2:0]  exp_rdy;
    ga[0] = a0; ga[1] = a1; ga[2] = a2;
    gd[0] = d; gd[1] = d + 32'd1; gd[2] = d + 32'd2;
    reset_n   = rst;
    flush_in  = fl;
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {gd[2], gd[1], gd[0]};
    #2;
    g = pick(rst, fl, v);
    exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
    rdy = req_ready;
    check("req_ready", req_ready, exp_rdy);
    @(posedge clk);
    if (!rst) begin
      m_rr = 1; m_starve = 0; m_wena = 0; m_fpu = 0; m_addr = 0; m_data = 0; m_src = 0;
    end else begin
      m_wena = (g >= 0) && (ga[g] != 6'd0);
      m_fpu  = m_wena && ga[g][5];
      if (g >= 0) begin
        m_addr = ga[g]; m_data = gd[g]; m_src = g;
      end
      if (g > 0) begin
        m_rr = (g == N - 1) ? 1 : g + 1;
        m_starve = 0;
      end else if (rr_pick(v, 1) < 0) begin
        m_starve = 0;
      end else if (g == 0 && m_starve < MAXW) begin
        m_starve = m_starve + 1;
      end
    end
    #1;
    check("wb_wena", wb_wena, m_wena);
    check("fpu_dirty", fpu_dirty, m_fpu);
    if (m_wena || !rst) begin
      check("wb_addr", wb_addr, m_addr);
      check("wb_data", wb_data, m_data);
      check("wb_src", wb_src, 64'(m_src));
    end
  endtask

  typedef struct {
    logic        rst, fl;
    logic [2:0]  v;
    logic [5:0]  a0, a1, a2;
    logic [31:0] d;
    logic [2:0]  rdy;
    logic        wena, ck;
    logic [5:0]  addr;
    logic [1:0]  src;
    logic        fpu;
    logic [31:0] xd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [2:0] r;
    logic [2:0] vv;
    logic [5:0] ra [3];

    vecs[0] = '{1'b1, 1'b0, 3'b001, 6'd5, 6'd0, 6'd0,  32'hDEADBEEF, 3'b001, 1'b1, 1'b1, 6'd5,  2'd0, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 3'b110, 6'd0, 6'd7, 6'd33, 32'h100, 3'b010, 1'b1, 1'b1, 6'd7,  2'd1, 1'b0, 32'h101};
    vecs[2] = '{1'b1, 1'b0, 3'b110, 6'd0, 6'd7, 6'd33, 32'h200, 3'b100, 1'b1, 1'b1, 6'd33, 2'd2, 1'b1, 32'h202};
    vecs[3] = '{1'b1, 1'b0, 3'b001, 6'd0, 6'd0, 6'd0,  32'h300, 3'b001, 1'b0, 1'b0, 6'd0,  2'd0, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 3'b100, 6'd0, 6'd0, 6'd32, 32'h400, 3'b100, 1'b1, 1'b1, 6'd32, 2'd2, 1'b1, 32'h402};
    vecs[5] = '{1'b1, 1'b1, 3'b011, 6'd3, 6'd9, 6'd0,  32'h500, 3'b010, 1'b1, 1'b1, 6'd9,  2'd1, 1'b0, 32'h501};
    vecs[6] = '{1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0,  32'h600, 3'b000, 1'b0, 1'b1, 6'd9,  2'd1, 1'b0, 32'h501};
    vecs[7] = '{1'b1, 1'b1, 3'b001, 6'd4, 6'd0, 6'd0,  32'h700, 3'b000, 1'b0, 1'b1, 6'd9,  2'd1, 1'b0, 32'h501};
    vecs[8] = '{1'b1, 1'b0, 3'b101, 6'd10, 6'd0, 6'd12, 32'h800, 3'b001, 1'b1, 1'b1, 6'd10, 2'd0, 1'b0, 32'h800};
    vecs[9] = '{1'b1, 1'b0, 3'b010, 6'd0, 6'd11, 6'd0, 32'h900, 3'b010, 1'b1, 1'b1, 6'd11, 2'd1, 1'b0, 32'h901};

    reset_n = 1'b0; flush_in = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    m_rr = 1; m_starve = 0; m_wena = 0; m_fpu = 0; m_addr = 0; m_data = 0; m_src = 0;
    @(posedge clk); #1;

    // Reset state, with requests presented while held in reset
    cycle(1'b0, 1'b0, 3'b111, 6'd1, 6'd2, 6'd3, 32'h11, r);
    check("rst_ready", r, 3'b000);
    cycle(1'b0, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 32'h0, r);
    check("rst_wena", wb_wena, 1'b0);
    check("rst_addr", wb_addr, 6'd0);
    check("rst_data", wb_data, 32'd0);
    check("rst_src", wb_src, 2'd0);
    check("rst_fpu", fpu_dirty, 1'b0);
    check("rst_rr_ptr", dut.rr_ptr, 2'd1);
    check("rst_starve", dut.starve_cnt, 3'd0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].rst, vecs[i].fl, vecs[i].v, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].d, r);
      check($sformatf("tbl%0d_ready", i), r, vecs[i].rdy);
      check($sformatf("tbl%0d_wena", i), wb_wena, vecs[i].wena);
      check($sformatf("tbl%0d_fpu", i), fpu_dirty, vecs[i].fpu);
      if (vecs[i].ck) begin
        check($sformatf("tbl%0d_addr", i), wb_addr, vecs[i].addr);
        check($sformatf("tbl%0d_src", i), wb_src, vecs[i].src);
        check($sformatf("tbl%0d_data", i), wb_data, vecs[i].xd);
      end
    end

    // Starvation: pipeline wins four times, then the waiting secondary is forced in
    for (int t = 0; t < 4; t++) begin
      cycle(1'b1, 1'b0, 3'b011, 6'd1, 6'd2, 6'd0, 32'h1000, r);
      check($sformatf("starve_t%0d_ready", t), r, 3'b001);
    end
    check("starve_cnt_sat", dut.starve_cnt, 3'd4);
    cycle(1'b1, 1'b0, 3'b011, 6'd1, 6'd2, 6'd0, 32'h1000, r);
    check("starve_force_ready", r, 3'b010);
    check("starve_force_src", wb_src, 2'd1);
    check("starve_cleared", dut.starve_cnt, 3'd0);

    // Round-robin alternation between the two secondaries from a fresh pointer
    cycle(1'b0, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 32'h0, r);
    for (int t = 0; t < 4; t++) begin
      cycle(1'b1, 1'b0, 3'b110, 6'd0, 6'd20, 6'd40, 32'h2000, r);
      check($sformatf("rr_t%0d_ready", t), r, (t % 2 == 0) ? 3'b010 : 3'b100);
      check($sformatf("rr_t%0d_ptr", t), dut.rr_ptr, (t % 2 == 0) ? 2'd2 : 2'd1);
    end

    // Reset mid-stream drops the in-flight write
    cycle(1'b1, 1'b0, 3'b111, 6'd13, 6'd14, 6'd15, 32'h3000, r);
    cycle(1'b0, 1'b0, 3'b111, 6'd13, 6'd14, 6'd15, 32'h3000, r);
    check("mid_rst_ready", r, 3'b000);
    check("mid_rst_wena", wb_wena, 1'b0);
    check("mid_rst_addr", wb_addr, 6'd0);
    check("mid_rst_data", wb_data, 32'd0);
    check("mid_rst_rr_ptr", dut.rr_ptr, 2'd1);
    check("mid_rst_starve", dut.starve_cnt, 3'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      vv = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 7))
          0:       ra[k] = 6'd0;
          1:       ra[k] = 6'd32;
          default: ra[k] = 6'($urandom_range(0, 63));
        endcase
      end
      cycle($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0, vv,
            ra[0], ra[1], ra[2], $urandom, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
